// File: rtl/stack_mem_if.sv
// Request, RAM and write-back signals of the stack/memory access sequencer.
interface stack_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Handshake: start is a one-cycle request strobe, sampled only while busy is low;
  // the sequencer answers with exactly one done pulse (with fault when rejected),
  // and any start seen while busy or during done is dropped, never queued.
  logic                  start;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] current_SP;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic [DATA_WIDTH-1:0] data_from_memory;
  logic [DATA_WIDTH-1:0] new_SP;

  modport master (
    output start, op, base_addr, offset, store_data, current_SP, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, fault, data_from_memory, new_SP
  );

  modport slave (
    input  start, op, base_addr, offset, store_data, current_SP, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, fault, data_from_memory, new_SP
  );
endinterface

// File: rtl/stack_mem_sequencer.sv
// Multi-cycle LOAD/STORE/PUSH/POP sequencer in front of a synchronous data RAM;
// returns read data and the updated stack pointer for register-bank write-back.
module stack_mem_sequencer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] STACK_LOW    = '0,
  parameter logic [DATA_WIDTH-1:0] STACK_HIGH   = DATA_WIDTH'(8191)
) (
  input  logic        fast_clock,
  input  logic        reset,
  stack_mem_if.slave  bus,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

  state_t                state, state_next;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] sp_q;
  logic [2:0]            wait_cnt;
  logic                  op_q_write;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] new_sp_q;

  logic                  req_fault;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] sp_minus_one;
  logic [DATA_WIDTH-1:0] done_sp;

  assign sp_minus_one = bus.current_SP - DATA_WIDTH'(1);
  assign req_write    = (bus.op == OP_STORE) || (bus.op == OP_PUSH);
  assign op_q_write   = (op_q == OP_STORE) || (op_q == OP_PUSH);

  // SP <= STACK_LOW covers both SP-1 < STACK_LOW and the SP==0 wrap.
  always_comb begin
    req_fault = 1'b0;
    req_addr  = bus.base_addr + bus.offset;
    case (bus.op)
      OP_PUSH: begin
        req_fault = (bus.current_SP <= STACK_LOW);
        req_addr  = ADDR_WIDTH'(sp_minus_one);
      end
      OP_POP: begin
        req_fault = (bus.current_SP >= STACK_HIGH);
        req_addr  = ADDR_WIDTH'(bus.current_SP);
      end
      default: ;
    endcase
  end

  always_comb begin
    done_sp = sp_q;
    case (op_q)
      OP_PUSH: done_sp = sp_q - DATA_WIDTH'(1);
      OP_POP:  done_sp = sp_q + DATA_WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = req_fault ? S_FAULT : S_ADDR;
      S_ADDR:  state_next = op_q_write ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_cnt == 3'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_FAULT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      op_q        <= OP_LOAD;
      sp_q        <= '0;
      wait_cnt    <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      data_q      <= '0;
      new_sp_q    <= STACK_HIGH;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          new_sp_q <= bus.current_SP;
          if (bus.start) begin
            op_q <= bus.op;
            sp_q <= bus.current_SP;
            if (!req_fault) begin
              mem_addr_q <= req_addr;
              if (req_write) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.store_data;
              end
            end
          end
        end
        S_ADDR: begin
          wait_cnt <= WAIT_INIT;
          if (op_q_write) new_sp_q <= done_sp;
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            data_q   <= bus.mem_rdata;
            new_sp_q <= done_sp;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.mem_we           = mem_we_q;
  assign bus.data_from_memory = data_q;
  assign bus.new_SP           = new_sp_q;
  assign bus.busy             = (state != S_IDLE);
  assign bus.done             = (state == S_DONE) || (state == S_FAULT);
  assign bus.fault            = (state == S_FAULT);
  assign debug_state          = state;

endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Directed bench for stack_mem_sequencer: vector table of single operations plus
// hand-written reset-abort and back-to-back start sequences.
module tb_stack_mem_sequencer;

  logic       fast_clock = 1'b0;
  logic       reset;
  logic [2:0] debug_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  stack_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  stack_mem_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(2),
    .STACK_LOW(32'd0), .STACK_HIGH(32'd8191)
  ) dut (
    .fast_clock  (fast_clock),
    .reset       (reset),
    .bus         (bus),
    .debug_state (debug_state)
  );

  always #5 fast_clock = ~fast_clock;

  // RAM model: address registered at edge T gives read data after edge T+2.
  logic [31:0] ram [0:16383];
  logic [31:0] rd_p1;
  always @(posedge fast_clock) begin
    if (bus.mem_we) ram[bus.mem_addr[13:0]] <= bus.mem_wdata;
    rd_p1         <= ram[bus.mem_addr[13:0]];
    bus.mem_rdata <= rd_p1;
  end

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] data;
    logic [31:0] sp;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [31:0] exp_dfm;
    logic [31:0] exp_sp;
    int          exp_lat;
  } vec_t;

  localparam logic [1:0] LD = 2'd0, ST = 2'd1, PU = 2'd2, PO = 2'd3;
  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   we_cnt;
    logic is_wr;
    is_wr          = (v.op == ST) || (v.op == PU);
    bus.op         = v.op;
    bus.base_addr  = v.base;
    bus.offset     = v.offset;
    bus.store_data = v.data;
    bus.current_SP = v.sp;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.base_addr  = 32'h0BAD_0BAD;
    bus.store_data = 32'h0BAD_0BAD;
    cyc    = 1;
    we_cnt = 0;
    check($sformatf("v%0d_busy", idx), bus.busy, 1'b1);
    if (!v.exp_fault) begin
      check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.exp_addr);
      check($sformatf("v%0d_we_in_addr", idx), bus.mem_we, is_wr);
      if (is_wr) check($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.data);
    end
    while (!bus.done && cyc < 20) begin
      if (bus.mem_we) we_cnt++;
      tick();
      cyc++;
    end
    if (bus.mem_we) we_cnt++;
    check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
    check($sformatf("v%0d_fault", idx), bus.fault, v.exp_fault);
    check($sformatf("v%0d_new_sp", idx), bus.new_SP, v.exp_sp);
    check($sformatf("v%0d_dfm", idx), bus.data_from_memory, v.exp_dfm);
    check($sformatf("v%0d_we_count", idx), we_cnt, (is_wr && !v.exp_fault) ? 1 : 0);
    bus.current_SP = v.sp ^ 32'h0000_0F0F;
    tick();
    check($sformatf("v%0d_done_pulse", idx), bus.done, 1'b0);
    check($sformatf("v%0d_idle", idx), bus.busy, 1'b0);
    tick();
    check($sformatf("v%0d_sp_track", idx), bus.new_SP, v.sp ^ 32'h0000_0F0F);
  endtask

  initial begin
    int done_cnt;
    int we_total;
    int last_done;
    int gap_bad;
    int extra_done;

    vecs[0]  = '{ST, 32'h0000_2000, 32'd4, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 32'h0000_2004, 32'h0,         32'h0000_1234, 2};
    vecs[1]  = '{LD, 32'h0000_2000, 32'd4, 32'h0,         32'h0000_0777, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0000_0777, 4};
    vecs[2]  = '{PU, 32'h0,         32'd0, 32'h0000_0055, 32'd8191,      1'b0, 32'd8190,      32'hDEAD_BEEF, 32'd8190,      2};
    vecs[3]  = '{PO, 32'h0,         32'd0, 32'h0,         32'd8190,      1'b0, 32'd8190,      32'h0000_0055, 32'd8191,      4};
    vecs[4]  = '{PO, 32'h0,         32'd0, 32'h0,         32'd8191,      1'b1, 32'h0,         32'h0000_0055, 32'd8191,      1};
    vecs[5]  = '{PU, 32'h0,         32'd0, 32'h0000_0099, 32'd0,         1'b1, 32'h0,         32'h0000_0055, 32'd0,         1};
    vecs[6]  = '{ST, 32'h0000_0000, 32'd4, 32'hCAFE_F00D, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'h0000_0055, 32'h0000_0010, 2};
    vecs[7]  = '{LD, 32'hFFFF_FFFC, 32'd8, 32'h0,         32'h0000_0020, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 32'h0000_0020, 4};
    vecs[8]  = '{PU, 32'h0,         32'd0, 32'h0000_A5A5, 32'd1,         1'b0, 32'd0,         32'hCAFE_F00D, 32'd0,         2};
    vecs[9]  = '{PO, 32'h0,         32'd0, 32'h0,         32'd8192,      1'b1, 32'h0,         32'hCAFE_F00D, 32'd8192,      1};
    vecs[10] = '{PO, 32'h0,         32'd0, 32'h0,         32'd0,         1'b0, 32'd0,         32'h0000_A5A5, 32'd1,         4};
    vecs[11] = '{PU, 32'h0,         32'd0, 32'h0000_1111, 32'd100,       1'b0, 32'd99,        32'h0000_A5A5, 32'd99,        2};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.op         = LD;
    bus.base_addr  = '0;
    bus.offset     = '0;
    bus.store_data = '0;
    bus.current_SP = 32'h0000_1234;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_dfm", bus.data_from_memory, 32'h0);
    check("rst_new_sp", bus.new_SP, 32'd8191);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a LOAD's WAIT phase aborts it cleanly.
    bus.op = LD; bus.base_addr = 32'h0000_2000; bus.offset = 32'd4;
    bus.current_SP = 32'd300;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("abort_in_wait", debug_state, 3'd2);
    reset = 1'b1;
    tick();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_we", bus.mem_we, 1'b0);
    check("abort_new_sp", bus.new_SP, 32'd8191);
    check("abort_dfm", bus.data_from_memory, 32'h0);
    reset = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done || bus.mem_we) extra_done++;
    end
    check("abort_no_completion", extra_done, 0);
    check("abort_sp_track", bus.new_SP, 32'd300);

    // start held high: one STORE every 3 cycles (ADDR, DONE, one IDLE).
    bus.op = ST; bus.base_addr = 32'h0000_3000; bus.offset = 32'd0;
    bus.store_data = 32'h0000_0001; bus.current_SP = 32'd500;
    bus.start = 1'b1;
    done_cnt = 0; we_total = 0; last_done = -1; gap_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.store_data = $urandom_range(1, 32'hFFFF);
      if (bus.mem_we) we_total++;
      if (bus.done) begin
        if (last_done >= 0 && c - last_done != 3) gap_bad++;
        if (last_done < 0 && c != 2) gap_bad++;
        last_done = c;
        done_cnt++;
      end
    end
    bus.start = 1'b0;
    check("held_done_count", done_cnt, 4);
    check("held_spacing", gap_bad, 0);
    check("held_we_count", we_total, 4);
    for (int c = 0; c < 3; c++) tick();
    check("held_drained", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
